// File: rtl/lmapa_sensores_avanco.sv
// Navigation core: 8x8 occupancy map, robot position, obstacle sensors and a
// 4-phase apply/sense/decide/encode step sequencer.
module lmapa_sensores_avanco #(
  parameter int unsigned START_ROW = 0,
  parameter int unsigned START_COL = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       under,
  input  logic [2:0] orientacao,
  input  logic       map_we,
  input  logic [5:0] map_addr,
  input  logic [1:0] map_data,
  output logic       head,
  output logic       left,
  output logic       barreira,
  output logic       avancar,
  output logic       girar,
  output logic       remover,
  output logic [2:0] acao,
  output logic [2:0] pos_row,
  output logic [2:0] pos_col,
  output logic [1:0] phase
);

  localparam int unsigned CELLS = 64;
  localparam logic [1:0] PH_APPLY  = 2'd0;
  localparam logic [1:0] PH_SENSE  = 2'd1;
  localparam logic [1:0] PH_DECIDE = 2'd2;
  localparam logic [1:0] PH_ENCODE = 2'd3;
  localparam logic [1:0] CELL_FREE    = 2'd0;
  localparam logic [1:0] CELL_BARRIER = 2'd2;

  logic [1:0] map_q [CELLS];
  logic [1:0] map_d [CELLS];
  logic [1:0] phase_q, phase_d;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [2:0] acao_q, acao_d;
  logic       head_q, head_d, left_q, left_d, barr_q, barr_d;
  logic       av_q, av_d, gi_q, gi_d, rm_q, rm_d;

  logic [6:0] nb_ahead, nb_left, nb_move;
  logic       hdg_ok;

  // Neighbour of (r,c) in direction d: {in_grid, row, col}
  function automatic logic [6:0] neighbor(input logic [2:0] r, input logic [2:0] c,
                                          input logic [1:0] d);
    logic       ok;
    logic [2:0] nr;
    logic [2:0] nc;
    ok = 1'b1;
    nr = r;
    nc = c;
    case (d)
      2'd0: begin ok = (r != 3'd0); nr = r - 3'd1; end
      2'd1: begin ok = (c != 3'd7); nc = c + 3'd1; end
      2'd2: begin ok = (r != 3'd7); nr = r + 3'd1; end
      default: begin ok = (c != 3'd0); nc = c - 3'd1; end
    endcase
    return {ok, nr, nc};
  endfunction

  assign hdg_ok   = ~orientacao[2];
  assign nb_ahead = neighbor(row_q, col_q, orientacao[1:0]);
  assign nb_left  = neighbor(row_q, col_q, orientacao[1:0] + 2'd3);
  assign nb_move  = neighbor(row_q, col_q, acao_q[1:0]);

  always_comb begin
    map_d   = map_q;
    phase_d = phase_q + 2'd1;
    row_d   = row_q;
    col_d   = col_q;
    acao_d  = acao_q;
    head_d  = head_q;
    left_d  = left_q;
    barr_d  = barr_q;
    av_d    = 1'b0;
    gi_d    = 1'b0;
    rm_d    = 1'b0;

    case (phase_q)
      PH_APPLY: begin
        if (acao_q[2]) begin
          if (nb_move[6] && map_q[nb_move[5:0]] == CELL_FREE) begin
            row_d = nb_move[5:3];
            col_d = nb_move[2:0];
          end
        end else if (acao_q == 3'b010 && hdg_ok && nb_ahead[6]) begin
          map_d[nb_ahead[5:0]] = CELL_FREE;
        end
      end
      PH_SENSE: begin
        // Out-of-grid or invalid heading reads as a wall
        head_d = !(hdg_ok && nb_ahead[6] && map_q[nb_ahead[5:0]] == CELL_FREE);
        left_d = !(hdg_ok && nb_left[6] && map_q[nb_left[5:0]] == CELL_FREE);
        barr_d = hdg_ok && nb_ahead[6] && map_q[nb_ahead[5:0]] == CELL_BARRIER;
      end
      PH_DECIDE: begin
        if (!under) begin
          if (barr_q)       rm_d = 1'b1;
          else if (!head_q) av_d = 1'b1;
          else              gi_d = 1'b1;
        end
      end
      PH_ENCODE: begin
        if (av_q)      acao_d = {1'b1, orientacao[1:0]};
        else if (rm_q) acao_d = 3'b010;
        else if (gi_q) acao_d = 3'b001;
        else           acao_d = 3'b000;
      end
      default: ;
    endcase

    // External map write overrides a same-cycle barrier removal
    if (map_we) map_d[map_addr] = map_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < CELLS; i++) map_q[i] <= CELL_FREE;
      phase_q <= PH_APPLY;
      row_q   <= 3'(START_ROW);
      col_q   <= 3'(START_COL);
      acao_q  <= 3'b000;
      head_q  <= 1'b0;
      left_q  <= 1'b0;
      barr_q  <= 1'b0;
      av_q    <= 1'b0;
      gi_q    <= 1'b0;
      rm_q    <= 1'b0;
    end else begin
      map_q   <= map_d;
      phase_q <= phase_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acao_q  <= acao_d;
      head_q  <= head_d;
      left_q  <= left_d;
      barr_q  <= barr_d;
      av_q    <= av_d;
      gi_q    <= gi_d;
      rm_q    <= rm_d;
    end
  end

  assign head     = head_q;
  assign left     = left_q;
  assign barreira = barr_q;
  assign avancar  = av_q;
  assign girar    = gi_q;
  assign remover  = rm_q;
  assign acao     = acao_q;
  assign pos_row  = row_q;
  assign pos_col  = col_q;
  assign phase    = phase_q;

endmodule

// File: tb/tb_lmapa_sensores_avanco.sv
// Directed bench for lmapa_sensores_avanco: two instances (start (0,0) and (1,0))
// share all inputs; each scenario restarts both with a reset.
module tb_lmapa_sensores_avanco;

  logic       clock = 1'b0;
  logic       reset;
  logic       under;
  logic [2:0] orientacao;
  logic       map_we;
  logic [5:0] map_addr;
  logic [1:0] map_data;

  logic       a_head, a_left, a_barr, a_av, a_gi, a_rm;
  logic [2:0] a_acao, a_row, a_col;
  logic [1:0] a_phase;
  logic       b_head, b_left, b_barr, b_av, b_gi, b_rm;
  logic [2:0] b_acao, b_row, b_col;
  logic [1:0] b_phase;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  lmapa_sensores_avanco #(.START_ROW(0), .START_COL(0)) dut_a (
    .clock(clock), .reset(reset), .under(under), .orientacao(orientacao),
    .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .head(a_head), .left(a_left), .barreira(a_barr), .avancar(a_av),
    .girar(a_gi), .remover(a_rm), .acao(a_acao), .pos_row(a_row),
    .pos_col(a_col), .phase(a_phase)
  );

  lmapa_sensores_avanco #(.START_ROW(1), .START_COL(0)) dut_b (
    .clock(clock), .reset(reset), .under(under), .orientacao(orientacao),
    .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .head(b_head), .left(b_left), .barreira(b_barr), .avancar(b_av),
    .girar(b_gi), .remover(b_rm), .acao(b_acao), .pos_row(b_row),
    .pos_col(b_col), .phase(b_phase)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in cycle 0 (phase 0) of a fresh run
  task automatic do_reset();
    reset  = 1'b1;
    map_we = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Write issued in the current cycle; returns one cycle later
  task automatic wr(input logic [2:0] r, input logic [2:0] c, input logic [1:0] d);
    map_we   = 1'b1;
    map_addr = {r, c};
    map_data = d;
    tick();
    map_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; under = 1'b0; orientacao = 3'd0;
    map_we = 1'b0; map_addr = 6'd0; map_data = 2'd0;

    // Empty map, heading E: advance
    orientacao = 3'd1;
    do_reset();
    chk("t1_c0_phase", 8'(a_phase), 8'd0);
    chk("t1_c0_acao",  8'(a_acao),  8'd0);
    chk("t1_c0_pos",   8'({a_row, a_col}), 8'd0);
    tick(); tick();
    chk("t1_c2_head",  8'(a_head), 8'd0);
    chk("t1_c2_left",  8'(a_left), 8'd1);
    chk("t1_c2_barr",  8'(a_barr), 8'd0);
    chk("t1_c2_phase", 8'(a_phase), 8'd2);
    tick();
    chk("t1_c3_pulses", 8'({a_av, a_gi, a_rm}), 8'b100);
    tick();
    chk("t1_c4_acao",  8'(a_acao), 8'b101);
    chk("t1_c4_av",    8'(a_av), 8'd0);
    chk("t1_c4_col",   8'(a_col), 8'd0);
    tick();
    chk("t1_c5_col",   8'(a_col), 8'd1);
    tick(); tick();
    chk("t1_c7_acao",  8'(a_acao), 8'b101);
    chk("t1_c7_phase", 8'(a_phase), 8'd3);

    // Empty map, heading N at row 0: turn
    orientacao = 3'd0;
    do_reset();
    tick(); tick();
    chk("t2_c2_head", 8'(a_head), 8'd1);
    chk("t2_c2_left", 8'(a_left), 8'd1);
    tick();
    chk("t2_c3_pulses", 8'({a_av, a_gi, a_rm}), 8'b010);
    tick();
    chk("t2_c4_girar", 8'(a_gi), 8'd0);
    chk("t2_c4_acao",  8'(a_acao), 8'b001);
    tick();
    chk("t2_c5_pos", 8'({a_row, a_col}), 8'd0);

    // Barrier ahead: remove, then advance
    orientacao = 3'd1;
    do_reset();
    wr(3'd0, 3'd1, 2'd2);
    tick();
    chk("t3_c2_head", 8'(a_head), 8'd1);
    chk("t3_c2_barr", 8'(a_barr), 8'd1);
    tick();
    chk("t3_c3_pulses", 8'({a_av, a_gi, a_rm}), 8'b001);
    tick();
    chk("t3_c4_acao", 8'(a_acao), 8'b010);
    tick(); tick();
    chk("t3_c6_head", 8'(a_head), 8'd0);
    chk("t3_c6_barr", 8'(a_barr), 8'd0);
    tick();
    chk("t3_c7_av", 8'(a_av), 8'd1);
    tick();
    chk("t3_c8_col", 8'(a_col), 8'd0);
    tick();
    chk("t3_c9_col", 8'(a_col), 8'd1);

    // Start (1,0), wall at (0,0) to the left, heading E: advance
    orientacao = 3'd1;
    do_reset();
    chk("t4_c0_row", 8'(b_row), 8'd1);
    wr(3'd0, 3'd0, 2'd1);
    tick();
    chk("t4_c2_left", 8'(b_left), 8'd1);
    chk("t4_c2_head", 8'(b_head), 8'd0);
    tick();
    chk("t4_c3_pulses", 8'({b_av, b_gi, b_rm}), 8'b100);

    // Same map, invalid heading 5: turn
    orientacao = 3'd5;
    do_reset();
    wr(3'd0, 3'd0, 2'd1);
    tick();
    chk("t4b_c2_head", 8'(b_head), 8'd1);
    chk("t4b_c2_left", 8'(b_left), 8'd1);
    chk("t4b_c2_barr", 8'(b_barr), 8'd0);
    tick();
    chk("t4b_c3_pulses", 8'({b_av, b_gi, b_rm}), 8'b010);
    tick();
    chk("t4b_c4_acao", 8'(b_acao), 8'b001);

    // Pause held for 3 steps
    orientacao = 3'd1;
    under = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      chk("t5_pulses", 8'({a_av, a_gi, a_rm}), 8'd0);
      tick();
    end
    chk("t5_acao", 8'(a_acao), 8'd0);
    chk("t5_pos",  8'({a_row, a_col}), 8'd0);
    under = 1'b0;

    // Reset in phase 2 of the second advancing step
    orientacao = 3'd1;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("t6_c5_col", 8'(a_col), 8'd1);
    tick();
    chk("t6_c6_phase", 8'(a_phase), 8'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_col",   8'(a_col), 8'd0);
    chk("t6_rst_acao",  8'(a_acao), 8'd0);
    chk("t6_rst_left",  8'(a_left), 8'd0);
    chk("t6_rst_av",    8'(a_av), 8'd0);
    chk("t6_rst_phase", 8'(a_phase), 8'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_c4_col", 8'(a_col), 8'd0);

    // Map write wins over same-cycle barrier removal
    orientacao = 3'd1;
    do_reset();
    wr(3'd0, 3'd1, 2'd2);
    tick(); tick(); tick();
    chk("t7_c4_acao", 8'(a_acao), 8'b010);
    wr(3'd0, 3'd1, 2'd1);
    tick();
    chk("t7_c6_head", 8'(a_head), 8'd1);
    chk("t7_c6_barr", 8'(a_barr), 8'd0);
    tick();
    chk("t7_c7_pulses", 8'({a_av, a_gi, a_rm}), 8'b010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
